// File: rtl/divider.sv
// Multi-cycle restoring divider, signed or unsigned, with flush and fixed latency.
// Define DIVIDER_FAST_EXCEPT_EN to finish divide-by-zero and signed overflow in one cycle.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_Clock,
    input  logic             i_nReset,
    input  logic             i_Start,
    input  logic             i_Signed,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Flush,
    output logic             o_Ready,
    output logic             o_Valid,
    output logic [WIDTH-1:0] o_Quotient,
    output logic [WIDTH-1:0] o_Remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, nstate;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] bmag;
    logic             qneg;
    logic             rneg;
    logic             dz;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] amag_in;
    logic [WIDTH-1:0] bmag_in;
    logic             is_dz;
    logic             fast;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic             last;

    assign accept  = i_Start && (state == IDLE) && !i_Flush;
    assign a_neg   = i_Signed & i_A[WIDTH-1];
    assign b_neg   = i_Signed & i_B[WIDTH-1];
    assign amag_in = a_neg ? (~i_A + 1'b1) : i_A;
    assign bmag_in = b_neg ? (~i_B + 1'b1) : i_B;
    assign is_dz   = (i_B == '0);

`ifdef DIVIDER_FAST_EXCEPT_EN
    logic is_ovf;
    assign is_ovf = i_Signed && (i_A == {1'b1, {(WIDTH-1){1'b0}}})
                    && (i_B == '1);
    assign fast   = is_dz | is_ovf;
`else
    assign fast   = 1'b0;
`endif

    // One restoring step: remainder needs an extra bit before the compare
    assign sh   = {rem, dvd[WIDTH-1]};
    assign diff = sh - {1'b0, bmag};
    assign ge   = (sh >= {1'b0, bmag});
    assign last = (cnt == CW'(1));

    always_ff @(posedge i_Clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nstate = fast ? DONE : RUN;
                end
            end
            RUN: begin
                if (i_Flush) begin
                    nstate = IDLE;
                end else if (last) begin
                    nstate = FIX;
                end
            end
            FIX: begin
                nstate = i_Flush ? IDLE : DONE;
            end
            DONE: begin
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        o_Ready = (state == IDLE);
        o_Valid = (state == DONE) && !i_Flush;
    end

    always_ff @(posedge i_Clock or negedge i_nReset) begin
        if (!i_nReset) begin
            dvd         <= '0;
            rem         <= '0;
            bmag        <= '0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            dz          <= 1'b0;
            cnt         <= '0;
            o_Quotient  <= '0;
            o_Remainder <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dvd  <= amag_in;
                        rem  <= '0;
                        bmag <= bmag_in;
                        qneg <= a_neg ^ b_neg;
                        rneg <= a_neg;
                        dz   <= is_dz;
                        cnt  <= CW'(WIDTH);
`ifdef DIVIDER_FAST_EXCEPT_EN
                        if (is_dz) begin
                            o_Quotient  <= '1;
                            o_Remainder <= i_A;
                        end else if (is_ovf) begin
                            o_Quotient  <= i_A;
                            o_Remainder <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    if (!i_Flush) begin
                        rem <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], ge};
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!i_Flush) begin
                        // Zero divisor: magnitude path gives all-ones, but sign fix must not apply
                        if (dz) begin
                            o_Quotient <= '1;
                        end else begin
                            o_Quotient <= qneg ? (~dvd + 1'b1) : dvd;
                        end
                        o_Remainder <= rneg ? (~rem + 1'b1) : rem;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results,
// a monitor pops and checks values and latency on every o_Valid.
module tb_divider;

    localparam int W = 32;
    localparam int LAT = W + 2;
`ifdef DIVIDER_FAST_EXCEPT_EN
    localparam int XLAT = 1;
`else
    localparam int XLAT = W + 2;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         ready;
    logic         valid;
    logic [W-1:0] q;
    logic [W-1:0] r;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    divider #(.WIDTH(W)) dut (
        .i_Clock    (clk),
        .i_nReset   (rst_n),
        .i_Start    (start),
        .i_Signed   (sgn),
        .i_A        (a),
        .i_B        (b),
        .i_Flush    (flush),
        .o_Ready    (ready),
        .o_Valid    (valid),
        .o_Quotient (q),
        .o_Remainder(r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid=1 want none at cyc %0d",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", q, e.q);
                chk("remainder", r, e.r);
                chk("latency", W'(cyc + 1 - e.acc), W'(e.lat));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=0 want 1");
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input bit push,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int lat);
        exp_t e;
        wait_ready();
        sgn   = s;
        a     = ia;
        b     = ib;
        start = 1'b1;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.acc = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        #12;
        chk("rst_ready", W'(ready), W'(1));
        chk("rst_valid", W'(valid), W'(0));
        chk("rst_q", q, '0);
        chk("rst_r", r, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 100, 7, 1, 14, 2, LAT);
        drain();
        issue(1, 32'hFFFFFFF9, 2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, LAT);
        drain();
        issue(1, 7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 1, LAT);
        drain();
        issue(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 1, 14, 32'hFFFFFFFE, LAT);
        drain();
        issue(0, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 0, LAT);
        drain();
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, LAT);
        drain();
        issue(1, 32'h12345678, 0, 1, 32'hFFFFFFFF, 32'h12345678, XLAT);
        drain();
        issue(0, 32'h12345678, 0, 1, 32'hFFFFFFFF, 32'h12345678, XLAT);
        drain();
        issue(1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0, XLAT);
        drain();
        issue(0, 32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h80000000, LAT);
        drain();

        // flush mid-run, then a fresh op two cycles later
        issue(0, 100, 7, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", W'(ready), W'(1));
        @(negedge clk);
        issue(0, 9, 3, 1, 3, 0, LAT);
        drain();

        // starts while busy must be dropped
        issue(0, 1000, 10, 1, 100, 0, LAT);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a     = 5;
            b     = 1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain();
        repeat (40) @(negedge clk);

        // reset mid-run discards the op
        issue(0, 100, 7, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", W'(ready), W'(1));
        chk("mid_rst_valid", W'(valid), W'(0));
        chk("mid_rst_q", q, '0);
        chk("mid_rst_r", r, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
